bayer_frame_source: RTL and testbench
=====================================

Name: bayer_frame_source

Overview:
Synthetic D5M capture source for the edge-detection pipeline. It emulates CCD_Capture and drives a raw Bayer stream with data-valid and X/Y coordinates, so the pipeline can be exercised in simulation and on hardware without the camera. It sits where CCD_Capture sits in the top level and drives the pipeline's iDATA/iDVAL/iX_Cont/iY_Cont directly. Selectable deterministic patterns give known grayscale and Sobel results.

Parameters:
H_ACTIVE, 1280, active Bayer pixels per row (even, >=4)
V_ACTIVE, 960, active Bayer rows per frame (even, >=4)
H_BLANK, 64, invalid cycles between rows (>=1)
V_BLANK, 256, invalid cycles after last row of frame (>=1)

Ports:
iCLK  in  1  pixel clock
iRST  in  1  synchronous, active-high reset
iStart  in  1  start free-running frames (level, sampled in IDLE)
iStop  in  1  stop request; 1-cycle pulse sufficient
iMode  in  2  pattern select, latched at each frame start
oDATA  out  12  Bayer pixel; 0 when oDVAL=0
oDVAL  out  1  pixel valid
oX_Cont  out  16  column of current pixel
oY_Cont  out  16  row of current pixel
oFrame_Cont  out  32  completed-frame count
oBusy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (iRST=1 at a clock edge): state=IDLE; all outputs 0; stop_pending=0; latched mode=0. Reset mid-frame aborts immediately. No partial-row flush.
- FSM states: IDLE, ACTIVE, HBLANK, VBLANK. All outputs are registered.
- IDLE -> ACTIVE when iStart=1. On the next cycle: oDVAL=1, X=0, Y=0, mode latched from iMode.
- ACTIVE: one pixel per cycle; X increments.
  - At X=H_ACTIVE-1 with Y<V_ACTIVE-1: go to HBLANK. X becomes 0 and Y becomes Y+1 on the first blank cycle.
  - At X=H_ACTIVE-1 with Y=V_ACTIVE-1: go to VBLANK. X and Y become 0. No HBLANK after the last row.
- HBLANK: exactly H_BLANK cycles with oDVAL=0, then ACTIVE.
- VBLANK: exactly V_BLANK cycles with oDVAL=0.
  - oFrame_Cont increments on the first VBLANK cycle and wraps at 2^32.
  - On the last VBLANK cycle: if stop_pending, go to IDLE and clear stop_pending. Otherwise go to ACTIVE and re-latch iMode.
- Frame period = V_ACTIVE*H_ACTIVE + (V_ACTIVE-1)*H_BLANK + V_BLANK cycles.
- iStop:
  - Sets stop_pending in any non-IDLE state. The current frame always completes.
  - Ignored in IDLE.
  - iStop and iStart both high in IDLE: the start wins.
- iStart while busy: ignored. iMode changes mid-frame: no effect until the next frame start.
- Patterns (pixel at row Y, column X):
  - Mode 0, flat Bayer: even Y/even X=R=0x800; odd Y/odd X=B=0x200; otherwise G=0x400. Each 2x2 block averages to 0x480.
  - Mode 1, ramp: {X[10:0],1'b0}.
  - Mode 2, checkerboard: (X[4]^Y[4]) ? 0xFFF : 0x000.
  - Mode 3, vertical edge: X < H_ACTIVE/2 ? 0x000 : 0xFFF.
- Counters: X is log2(H_ACTIVE) bits and Y is log2(V_ACTIVE) bits, zero-extended to 16. Blank counter is sized for max(H_BLANK, V_BLANK).

Decomposition:
- Shared package bayer_src_pkg holds:
  - state enum (IDLE/ACTIVE/HBLANK/VBLANK);
  - mode constants MODE_FLAT=0, MODE_RAMP=1, MODE_CHECK=2, MODE_VEDGE=3;
  - flat colour constants R_FLAT=0x800, G_FLAT=0x400, B_FLAT=0x200.
- One combinational sub-module, bayer_pattern_gen, maps (X, Y, mode) to the 12-bit pixel. The top holds the FSM, counters and output registers.

Test Plan:
All scenarios use H_ACTIVE=8, V_ACTIVE=4, H_BLANK=2, V_BLANK=3 (frame period 41).
- Start, mode 0: pulse iStart. The next cycle shows oDVAL=1, X=0, Y=0, oDATA=0x800. Row 0 alternates 0x800/0x400 for 8 cycles, then 2 cycles of oDVAL=0 with Y=1. Row 1 starts 0x400, 0x200.
- Frame timing, iStart held: exactly 32 oDVAL cycles per frame and 41-cycle spacing between the X=0,Y=0 pixels. oFrame_Cont=1 after the first VBLANK entry and 2 after the second.
- Stop mid-frame: pulse iStop at row 1, X=3. The frame completes with all 32 pixels, then IDLE with oBusy=0 and oFrame_Cont=1. There are no further oDVAL pulses.
- Mode latch: set iMode=3 at frame start, then change to 2 mid-frame. The whole frame is X<4 -> 0x000, X>=4 -> 0xFFF. The next frame is checkerboard (all 0x000, since X,Y<16).
- Reset mid-row at row 2, X=5: every output is 0 on the next cycle and the state is IDLE. A new iStart resumes at X=0, Y=0.
- End-to-end: mode 0 feeding image_processing_pipeline gives constant grayscale 0x480. Interior Sobel outputs give edge 0 (rows/cols beyond the border).

Source files
------------

// File: rtl/bayer_src_pkg.sv
// Shared types and constants for the synthetic Bayer frame source.
package bayer_src_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StActive = 2'd1,
        StHblank = 2'd2,
        StVblank = 2'd3
    } state_e;

    // Pattern select encodings
    localparam logic [1:0] MODE_FLAT  = 2'd0;
    localparam logic [1:0] MODE_RAMP  = 2'd1;
    localparam logic [1:0] MODE_CHECK = 2'd2;
    localparam logic [1:0] MODE_VEDGE = 2'd3;

    // Flat Bayer colour levels; a 2x2 RGGB block averages to 0x480
    localparam logic [11:0] R_FLAT = 12'h800;
    localparam logic [11:0] G_FLAT = 12'h400;
    localparam logic [11:0] B_FLAT = 12'h200;

    localparam logic [11:0] PIX_BLACK = 12'h000;
    localparam logic [11:0] PIX_WHITE = 12'hFFF;

endpackage

// File: rtl/bayer_pattern_gen.sv
// Combinational test-pattern lookup: (x, y, mode) -> 12-bit Bayer pixel.
module bayer_pattern_gen
    import bayer_src_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  mode,
    output logic [11:0] pixel
);

    localparam logic [15:0] X_HALF = 16'(H_ACTIVE / 2);

    // Only the row parity and bit 4 matter for the row-dependent patterns
    logic unused_y_bits;
    assign unused_y_bits = ^{y[15:5], y[3:1]};

    // Select the pattern value for the addressed pixel
    always_comb begin
        pixel = PIX_BLACK;
        unique case (mode)
            MODE_FLAT: begin
                if (!y[0] && !x[0]) begin
                    pixel = R_FLAT;
                end else if (y[0] && x[0]) begin
                    pixel = B_FLAT;
                end else begin
                    pixel = G_FLAT;
                end
            end
            MODE_RAMP:  pixel = {x[10:0], 1'b0};
            MODE_CHECK: pixel = (x[4] ^ y[4]) ? PIX_WHITE : PIX_BLACK;
            MODE_VEDGE: pixel = (x < X_HALF) ? PIX_BLACK : PIX_WHITE;
            default:    pixel = PIX_BLACK;
        endcase
    end

endmodule

// File: rtl/bayer_frame_source.sv
// Synthetic D5M capture source: free-running raw Bayer frames with
// data-valid, X/Y coordinates and a completed-frame counter.
module bayer_frame_source
    import bayer_src_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned V_BLANK  = 256
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic        iStop,
    input  logic [1:0]  iMode,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [15:0] oX_Cont,
    output logic [15:0] oY_Cont,
    output logic [31:0] oFrame_Cont,
    output logic        oBusy
);

    localparam int unsigned XW        = $clog2(H_ACTIVE);
    localparam int unsigned YW        = $clog2(V_ACTIVE);
    localparam int unsigned MAX_BLANK = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int unsigned BW        = $clog2(MAX_BLANK + 1);

    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_LAST = BW'(V_BLANK - 1);

    state_e        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [BW-1:0] blank_q, blank_d;
    logic [1:0]    mode_q, mode_d;
    logic          stop_pending_q, stop_pending_d;
    logic [31:0]   frame_q, frame_d;
    logic          dval_q, dval_d;
    logic [11:0]   data_q, data_d;
    logic [11:0]   pixel;

    // Pixel for the coordinates that will be presented after this edge
    bayer_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .x     (16'(x_d)),
        .y     (16'(y_d)),
        .mode  (mode_d),
        .pixel (pixel)
    );

    // Next-state logic for the frame FSM, counters and outputs
    always_comb begin
        state_d        = state_q;
        x_d            = x_q;
        y_d            = y_q;
        blank_d        = blank_q;
        mode_d         = mode_q;
        stop_pending_d = stop_pending_q;
        frame_d        = frame_q;

        unique case (state_q)
            StIdle: begin
                // A stop request here is meaningless; start wins over stop
                stop_pending_d = 1'b0;
                if (iStart) begin
                    state_d = StActive;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = iMode;
                end
            end
            StActive: begin
                if (iStop) begin
                    stop_pending_d = 1'b1;
                end
                if (x_q == X_LAST) begin
                    x_d     = '0;
                    blank_d = '0;
                    if (y_q == Y_LAST) begin
                        // Last row goes straight to vertical blank
                        state_d = StVblank;
                        y_d     = '0;
                        frame_d = frame_q + 32'd1;
                    end else begin
                        state_d = StHblank;
                        y_d     = y_q + YW'(1);
                    end
                end else begin
                    x_d = x_q + XW'(1);
                end
            end
            StHblank: begin
                if (iStop) begin
                    stop_pending_d = 1'b1;
                end
                if (blank_q == HB_LAST) begin
                    state_d = StActive;
                end else begin
                    blank_d = blank_q + BW'(1);
                end
            end
            StVblank: begin
                if (blank_q == VB_LAST) begin
                    // A stop arriving on the final blank cycle still ends this frame
                    if (stop_pending_q || iStop) begin
                        state_d        = StIdle;
                        stop_pending_d = 1'b0;
                    end else begin
                        state_d = StActive;
                        mode_d  = iMode;
                    end
                end else begin
                    blank_d = blank_q + BW'(1);
                    if (iStop) begin
                        stop_pending_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        dval_d = (state_d == StActive);
        data_d = dval_d ? pixel : 12'h000;
    end

    // State and registered outputs with synchronous reset
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q        <= StIdle;
            x_q            <= '0;
            y_q            <= '0;
            blank_q        <= '0;
            mode_q         <= MODE_FLAT;
            stop_pending_q <= 1'b0;
            frame_q        <= '0;
            dval_q         <= 1'b0;
            data_q         <= '0;
        end else begin
            state_q        <= state_d;
            x_q            <= x_d;
            y_q            <= y_d;
            blank_q        <= blank_d;
            mode_q         <= mode_d;
            stop_pending_q <= stop_pending_d;
            frame_q        <= frame_d;
            dval_q         <= dval_d;
            data_q         <= data_d;
        end
    end

    assign oDATA       = data_q;
    assign oDVAL       = dval_q;
    assign oX_Cont     = 16'(x_q);
    assign oY_Cont     = 16'(y_q);
    assign oFrame_Cont = frame_q;
    assign oBusy       = (state_q != StIdle);

endmodule

// File: tb/tb_bayer_frame_source.sv
// Randomized self-checking bench for bayer_frame_source against a
// frame-position reference model.
module tb_bayer_frame_source;

    localparam int H  = 8;
    localparam int V  = 4;
    localparam int HB = 2;
    localparam int VB = 3;
    localparam int ROW_PERIOD = H + HB;
    localparam int VB_START   = V * H + (V - 1) * HB;
    localparam int PERIOD     = VB_START + VB;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [11:0] data;
    logic        dval;
    logic [15:0] x_cont;
    logic [15:0] y_cont;
    logic [31:0] frame_cont;
    logic        busy;

    int total;
    int bad;

    // Reference model: position within the frame period
    bit          m_running;
    int          m_pos;
    int          m_mode;
    bit          m_stop;
    logic [31:0] m_frames;

    bayer_frame_source #(
        .H_ACTIVE (H),
        .V_ACTIVE (V),
        .H_BLANK  (HB),
        .V_BLANK  (VB)
    ) dut (
        .iCLK        (clk),
        .iRST        (rst),
        .iStart      (start),
        .iStop       (stop),
        .iMode       (mode),
        .oDATA       (data),
        .oDVAL       (dval),
        .oX_Cont     (x_cont),
        .oY_Cont     (y_cont),
        .oFrame_Cont (frame_cont),
        .oBusy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] ref_pix(input int px, input int py, input int pm);
        case (pm)
            0: begin
                if (py % 2 == 0 && px % 2 == 0) return 12'h800;
                if (py % 2 == 1 && px % 2 == 1) return 12'h200;
                return 12'h400;
            end
            1: return 12'((px * 2) % 4096);
            2: return (((px / 16) % 2) != ((py / 16) % 2)) ? 12'hFFF : 12'h000;
            default: return (px < H / 2) ? 12'h000 : 12'hFFF;
        endcase
    endfunction

    task automatic model_step(input bit r, input bit s, input bit p, input int md);
        if (r) begin
            m_running = 0;
            m_pos     = 0;
            m_mode    = 0;
            m_stop    = 0;
            m_frames  = '0;
        end else if (!m_running) begin
            if (s) begin
                m_running = 1;
                m_pos     = 0;
                m_mode    = md;
            end
        end else begin
            if (p) m_stop = 1;
            if (m_pos == PERIOD - 1) begin
                if (m_stop) begin
                    m_running = 0;
                    m_stop    = 0;
                end else begin
                    m_pos  = 0;
                    m_mode = md;
                end
            end else begin
                m_pos++;
                if (m_pos == VB_START) m_frames = m_frames + 32'd1;
            end
        end
    endtask

    task automatic compare_all();
        int          ex, ey;
        bit          ev;
        logic [11:0] ed;
        ex = 0; ey = 0; ev = 0; ed = 12'h000;
        if (m_running && m_pos < VB_START) begin
            if (m_pos % ROW_PERIOD < H) begin
                ev = 1;
                ex = m_pos % ROW_PERIOD;
                ey = m_pos / ROW_PERIOD;
                ed = ref_pix(ex, ey, m_mode);
            end else begin
                ey = m_pos / ROW_PERIOD + 1;
            end
        end
        check_eq("dval",  32'(dval),   32'(ev));
        check_eq("data",  32'(data),   32'(ed));
        check_eq("x",     32'(x_cont), 32'(ex));
        check_eq("y",     32'(y_cont), 32'(ey));
        check_eq("frame", frame_cont,  m_frames);
        check_eq("busy",  32'(busy),   32'(m_running));
    endtask

    task automatic tick(input bit r, input bit s, input bit p, input int md);
        rst   = r;
        start = s;
        stop  = p;
        mode  = 2'(md);
        @(posedge clk);
        model_step(r, s, p, md);
        #1;
        compare_all();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0;
        model_step(1, 0, 0, 0);

        // Reset state
        tick(1, 0, 0, 0);
        tick(1, 1, 1, 2);
        check_eq("rst_dval", 32'(dval), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_frame", frame_cont, 32'd0);

        // Start in flat mode; mode change mid-frame must not take effect
        tick(0, 1, 0, 0);
        check_eq("first_dval", 32'(dval), 32'd1);
        check_eq("first_data", 32'(data), 32'h800);
        tick(0, 0, 0, 3);
        check_eq("second_data", 32'(data), 32'h400);
        check_eq("second_x", 32'(x_cont), 32'd1);
        for (int i = 0; i < 40; i++) tick(0, 0, 0, 3);
        check_eq("f2_x", 32'(x_cont), 32'd0);
        check_eq("f2_dval", 32'(dval), 32'd1);
        check_eq("f2_data", 32'(data), 32'h000);
        check_eq("f2_frame", frame_cont, 32'd1);

        // Stop early in frame 2; frame completes, then idle
        tick(0, 0, 1, 3);
        for (int i = 0; i < 41; i++) tick(0, 0, 0, 1);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_frame", frame_cont, 32'd2);

        // Randomized run against the model
        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 499) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 59) == 0),
                 int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
